// File: rtl/sdrc_bs_pkg.sv
// Shared definitions for the app-to-SDRAM bus-width adapter:
// SDR width mode encodings, adapter FSM states and the ratio helper.
package sdrc_bs_pkg;

    localparam logic [1:0] MODE_FULL    = 2'b00;  // SDR_DW-wide lanes
    localparam logic [1:0] MODE_HALF    = 2'b01;  // SDR_DW/2-wide lanes
    localparam logic [1:0] MODE_QUARTER = 2'b10;  // SDR_DW/4-wide lanes
    localparam logic [1:0] MODE_BYTE    = 2'b11;  // 8-bit lanes

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } bs_state_e;

    // log2 of R = APP_DW / lane width for a given mode. Lane width never
    // drops below 8 bits; modes that would do so are clamped to a byte lane.
    function automatic logic [3:0] ratio_log2(input logic [1:0] mode,
                                              input int         app_dw_log2,
                                              input int         sdr_dw_log2);
        int lane_log2;
        if (mode == MODE_BYTE) begin
            lane_log2 = 3;
        end else begin
            lane_log2 = sdr_dw_log2 - int'(mode);
        end
        if (lane_log2 < 3) begin
            lane_log2 = 3;
        end
        return 4'(app_dw_log2 - lane_log2);
    endfunction

endpackage

// File: rtl/sdrc_bs_rd_pack.sv
// Read assembly: merges narrow SDR beats into one app word, lane by lane,
// and presents the completed word with a one-cycle valid pulse.
module sdrc_bs_rd_pack
    import sdrc_bs_pkg::*;
#(
    parameter int APP_DW = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              beat_en_i,    // a read beat is accepted this cycle
    input  logic              beat_last_i,  // the beat fills the top lane
    input  logic [APP_DW-1:0] beat_data_i,  // beat already shifted to its lane
    input  logic [APP_DW-1:0] beat_mask_i,  // ones over the lane being written
    output logic [APP_DW-1:0] rd_data_o,
    output logic              rd_valid_o
);

    logic [APP_DW-1:0] asm_q;
    logic [APP_DW-1:0] asm_d;
    logic [APP_DW-1:0] rd_data_q;
    logic              rd_valid_q;

    // Overwrite only the addressed lane of the assembly word.
    always_comb begin
        asm_d = asm_q;
        if (beat_en_i) begin
            asm_d = (asm_q & ~beat_mask_i) | beat_data_i;
        end
    end

    // Hold the partial word; publish it when the top lane lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            rd_valid_q <= beat_en_i & beat_last_i;
            if (beat_en_i && beat_last_i) begin
                rd_data_q <= asm_d;
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/sdrc_bs_adapter.sv
// App-to-SDRAM bus-width adapter. Registers each app request, scales its
// address and length into SDR beats for the latched width mode, splits
// write words into lanes (lowest lane first) and assembles read beats.
module sdrc_bs_adapter
    import sdrc_bs_pkg::*;
#(
    parameter int APP_AW = 30,
    parameter int APP_DW = 64,
    parameter int APP_BW = APP_DW / 8,
    parameter int APP_RW = 9,
    parameter int SDR_DW = 32,
    parameter int SDR_BW = SDR_DW / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        sdr_width,
    input  logic              app_sdr_req,
    input  logic [APP_AW-1:0] app_req_addr,
    input  logic [APP_RW-1:0] app_req_len,
    input  logic              app_req_wr_n,
    input  logic              app_req_dma_last,
    output logic              app_req_ack,
    output logic              app_sdr_req_int,
    output logic [APP_AW+2:0] app_req_addr_int,
    output logic [APP_RW+2:0] app_req_len_int,
    output logic              app_req_wr_n_int,
    output logic              app_req_dma_last_int,
    input  logic              app_req_ack_int,
    input  logic [APP_DW-1:0] app_wr_data,
    input  logic [APP_BW-1:0] app_wr_en_n,
    output logic              app_wr_next,
    output logic [SDR_DW-1:0] app_wr_data_int,
    output logic [SDR_BW-1:0] app_wr_en_n_int,
    input  logic              app_wr_next_int,
    input  logic [SDR_DW-1:0] app_rd_data_int,
    input  logic              app_rd_valid_int,
    output logic [APP_DW-1:0] app_rd_data,
    output logic              app_rd_valid,
    output logic              busy
);

    localparam int LANE_W      = $clog2(APP_BW);
    localparam int CNT_W       = APP_RW + 3;
    localparam int APP_DW_LOG2 = $clog2(APP_DW);
    localparam int SDR_DW_LOG2 = $clog2(SDR_DW);

    bs_state_e         state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [APP_AW-1:0] addr_q, addr_d;
    logic [APP_RW-1:0] len_q, len_d;
    logic              wr_n_q, wr_n_d;
    logic              dma_last_q, dma_last_d;
    logic              req_int_q, req_int_d;
    logic              zero_ack_q, zero_ack_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LANE_W-1:0] lane_q, lane_d;

    logic [3:0]             log2r;       // log2 of beats per app word
    logic [3:0]             log2w;       // log2 of lane width in bits
    logic [LANE_W-1:0]      last_lane;
    logic                   lane_is_last;
    logic [SDR_DW-1:0]      lane_mask;   // ones over the active low bits
    logic [SDR_BW-1:0]      byte_mask;
    logic [APP_DW_LOG2-1:0] bit_shift;   // bit offset of current lane
    logic [LANE_W-1:0]      byte_shift;  // byte offset of current lane
    logic [APP_DW-1:0]      wr_shift;
    logic [APP_BW-1:0]      en_shift;
    logic                   beat_step;

    assign log2r        = ratio_log2(mode_q, APP_DW_LOG2, SDR_DW_LOG2);
    assign log2w        = 4'(APP_DW_LOG2) - log2r;
    assign last_lane    = LANE_W'((32'd1 << log2r) - 32'd1);
    assign lane_is_last = (lane_q == last_lane);
    assign bit_shift    = APP_DW_LOG2'(lane_q) << log2w;
    assign byte_shift   = lane_q << (log2w - 4'd3);

    genvar gi;
    generate
        for (gi = 0; gi < SDR_DW; gi++) begin : g_lane_mask
            assign lane_mask[gi] = (32'(gi) < (32'd1 << log2w));
        end
        for (gi = 0; gi < SDR_BW; gi++) begin : g_byte_mask
            assign byte_mask[gi] = (32'(gi) < (32'd1 << (log2w - 4'd3)));
        end
    endgenerate

    // Write lane selection: unused high data bits 0, unused enables 1.
    assign wr_shift        = app_wr_data >> bit_shift;
    assign en_shift        = app_wr_en_n >> byte_shift;
    assign app_wr_data_int = (state_q == ST_WR) ? (wr_shift[SDR_DW-1:0] & lane_mask) : '0;
    assign app_wr_en_n_int = (state_q == ST_WR) ? (en_shift[SDR_BW-1:0] | ~byte_mask) : '1;
    assign app_wr_next     = (state_q == ST_WR) && app_wr_next_int && lane_is_last;

    // A data beat moves the burst forward in either direction.
    assign beat_step = ((state_q == ST_WR) && app_wr_next_int) ||
                       ((state_q == ST_RD) && app_rd_valid_int);

    // Request path outputs, scaled from the latched request and mode.
    assign app_sdr_req_int      = req_int_q;
    assign app_req_addr_int     = (APP_AW+3)'(addr_q) << log2r;
    assign app_req_len_int      = (APP_RW+3)'(len_q) << log2r;
    assign app_req_wr_n_int     = wr_n_q;
    assign app_req_dma_last_int = dma_last_q;
    assign busy                 = (state_q != ST_IDLE);

    // Next-state logic: request capture, core handshake, beat counting.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wr_n_d      = wr_n_q;
        dma_last_d  = dma_last_q;
        req_int_d   = req_int_q;
        zero_ack_d  = 1'b0;
        beat_cnt_d  = beat_cnt_q;
        lane_d      = lane_q;
        app_req_ack = zero_ack_q;
        case (state_q)
            ST_IDLE: begin
                // While a zero-length ack is out, the app still holds req.
                if (app_sdr_req && !zero_ack_q) begin
                    if (app_req_len != '0) begin
                        mode_d     = sdr_width;
                        addr_d     = app_req_addr;
                        len_d      = app_req_len;
                        wr_n_d     = app_req_wr_n;
                        dma_last_d = app_req_dma_last;
                        req_int_d  = 1'b1;
                        state_d    = ST_REQ;
                    end else begin
                        zero_ack_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (app_req_ack_int) begin
                    app_req_ack = 1'b1;
                    req_int_d   = 1'b0;
                    beat_cnt_d  = CNT_W'(len_q) << log2r;
                    lane_d      = '0;
                    state_d     = wr_n_q ? ST_RD : ST_WR;
                end
            end
            ST_WR, ST_RD: begin
                if (beat_step) begin
                    lane_d     = lane_is_last ? '0 : lane_q + 1'b1;
                    beat_cnt_d = beat_cnt_q - 1'b1;
                    if (beat_cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            wr_n_q     <= 1'b0;
            dma_last_q <= 1'b0;
            req_int_q  <= 1'b0;
            zero_ack_q <= 1'b0;
            beat_cnt_q <= '0;
            lane_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wr_n_q     <= wr_n_d;
            dma_last_q <= dma_last_d;
            req_int_q  <= req_int_d;
            zero_ack_q <= zero_ack_d;
            beat_cnt_q <= beat_cnt_d;
            lane_q     <= lane_d;
        end
    end

    sdrc_bs_rd_pack #(
        .APP_DW (APP_DW)
    ) u_rd_pack (
        .clk         (clk),
        .reset_n     (reset_n),
        .beat_en_i   ((state_q == ST_RD) && app_rd_valid_int),
        .beat_last_i (lane_is_last),
        .beat_data_i (APP_DW'(app_rd_data_int & lane_mask) << bit_shift),
        .beat_mask_i (APP_DW'(lane_mask) << bit_shift),
        .rd_data_o   (app_rd_data),
        .rd_valid_o  (app_rd_valid)
    );

endmodule
